sram_responder: RTL and testbench
=================================

SRAM_RESPONDER -- requirements
Module: sram_responder

Interface
Parameters:
REQ-001 Parameter ADDR_BITS, default 10, SHALL set the number of low ADDR bits decoded, giving 2**ADDR_BITS words of 16 bits.
REQ-002 Parameter RD_LATENCY, default 1, legal range 1..3, SHALL set the read latency in cycles.
Ports:
REQ-003 Clk  input  1  SHALL be the single clock; all state updates on the rising edge.
REQ-004 Reset  input  1  SHALL be the synchronous, active-high reset, sampled on the rising edge of Clk.
REQ-005 ADDR  input  16  SHALL be the word address from the CPU-side MAR.
REQ-006 Data_to_SRAM  input  16  SHALL be the write data from the CPU side.
REQ-007 OE  input  1  SHALL be the active-low read enable.
REQ-008 WE  input  1  SHALL be the active-low write enable.
REQ-009 Data_from_SRAM  output  16  SHALL be the registered read data returned to the CPU side.
REQ-010 Ready  output  1  SHALL be high when the block accepts accesses (SERVE state).

Function
REQ-011 The block SHALL implement the states INIT and SERVE.
REQ-012 INIT SHALL write one word per cycle at index counter 0..2**ADDR_BITS-1, then enter SERVE on the cycle after the last index; INIT therefore lasts exactly 2**ADDR_BITS cycles.
REQ-013 In INIT, Ready SHALL be 0 and OE/WE SHALL be ignored, with no memory side effects.
REQ-014 In SERVE, WE=0 sampled at an edge with ADDR in range SHALL write Data_to_SRAM to mem[ADDR[ADDR_BITS-1:0]] at that edge.
REQ-015 WE held low for multiple cycles SHALL rewrite on every cycle; the last sampled data wins.
REQ-016 In SERVE with OE=0 and WE=1, Data_from_SRAM SHALL present mem[ADDR] exactly RD_LATENCY rising edges after the sampling edge, through a pipeline that advances every cycle.
REQ-017 When OE=0 and WE=0 together, the write SHALL take priority, no read SHALL be issued, and Data_from_SRAM SHALL hold its value.
REQ-018 A read issued on the cycle after a write to the same address SHALL return the newly written data (write-before-read ordering).
REQ-019 An address with any bit above ADDR_BITS-1 set SHALL be out of range: writes are dropped and reads return 16'h0000.
REQ-020 When no read completes in a cycle, Data_from_SRAM SHALL hold its previous value.
REQ-021 A read issued on the last INIT cycle SHALL be ignored; the first accepted access is sampled at the edge where Ready is already 1.

Reset
REQ-022 Reset=1 SHALL force INIT, clear the index counter, set Ready=0, set Data_from_SRAM=16'h0000, and flush the read pipeline.
REQ-023 Reset asserted mid-INIT or mid-read SHALL restart INIT from index 0 and discard in-flight reads.
REQ-024 Memory contents SHALL NOT be cleared by Reset itself, only by the subsequent INIT sweep.

Configuration
REQ-025 Macro SRAM_RESPONDER_PRELOAD_EN defined: INIT SHALL write a fixed program image, with word i = image[i] for i < 16 (image[0] = 16'h5020, image[1] = 16'h1025, image[2..15] = 16'h0000), and 16'h0000 elsewhere.
REQ-026 Macro not defined: INIT SHALL write 16'h0000 to every word, and no image table SHALL be synthesized.

Verification
REQ-027 Reset for 1 cycle, then idle -> Ready=0 for exactly 1024 cycles (default parameters), then Ready=1; Data_from_SRAM=16'h0000 throughout.
REQ-028 After Ready: WE=0, ADDR=16'h0010, Data_to_SRAM=16'hBEEF for 1 cycle; then OE=0 at ADDR 16'h0010 -> Data_from_SRAM=16'hBEEF 1 cycle later; with RD_LATENCY=3 it appears 3 cycles later.
REQ-029 OE=0 and WE=0 together at ADDR 16'h0020 with data 16'h1234 -> Data_from_SRAM unchanged; a later read of 16'h0020 returns 16'h1234.
REQ-030 Write 16'hAAAA to ADDR 16'h0400 (out of range), then read 16'h0400 and 16'h0000 -> both return 16'h0000 (no alias).
REQ-031 Reset pulsed 500 cycles into INIT -> Ready stays 0 for 1024 cycles after reset deasserts; a value written before the reset reads back as 16'h0000 after INIT.
REQ-032 With SRAM_RESPONDER_PRELOAD_EN defined: read ADDR 0 and 1 after Ready -> 16'h5020, 16'h1025; without the macro -> 16'h0000, 16'h0000.

Source files
------------

// File: rtl/sram_responder.sv
// Word-addressed 16-bit SRAM responder: INIT sweep, then pipelined reads/writes.
// Define SRAM_RESPONDER_PRELOAD_EN to sweep a small program image instead of zeros.
module sram_responder #(
    parameter int ADDR_BITS  = 10,
    parameter int RD_LATENCY = 1
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [15:0] ADDR,
    input  logic [15:0] Data_to_SRAM,
    input  logic        OE,
    input  logic        WE,
    output logic [15:0] Data_from_SRAM,
    output logic        Ready
);

    localparam int DEPTH = 1 << ADDR_BITS;
    localparam logic [ADDR_BITS-1:0] IDX_LAST = ADDR_BITS'(DEPTH - 1);

    typedef enum logic {
        ST_INIT,
        ST_SERVE
    } state_e;

    state_e                 state_q, state_d;
    logic [ADDR_BITS-1:0]   idx_q, idx_d;
    logic [15:0]            mem_q [DEPTH];
    logic [RD_LATENCY-1:0]  pv_q, pv_d;
    logic [15:0]            pd_q [RD_LATENCY];
    logic [15:0]            pd_d [RD_LATENCY];
    logic [15:0]            dout_q, dout_d;

    logic                   in_range;
    logic                   wr_en;
    logic [ADDR_BITS-1:0]   waddr;
    logic [15:0]            wdata;
    logic                   rd_issue;
    logic [15:0]            rd_data;
    logic [15:0]            init_word;

`ifdef SRAM_RESPONDER_PRELOAD_EN
    always_comb begin
        init_word = 16'h0000;
        if (idx_q == ADDR_BITS'(0)) begin
            init_word = 16'h5020;
        end else if (idx_q == ADDR_BITS'(1)) begin
            init_word = 16'h1025;
        end
    end
`else
    assign init_word = 16'h0000;
`endif

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        wr_en    = 1'b0;
        waddr    = idx_q;
        wdata    = init_word;
        rd_issue = 1'b0;
        in_range = (ADDR >> ADDR_BITS) == 16'h0000;
        rd_data  = in_range ? mem_q[ADDR[ADDR_BITS-1:0]] : 16'h0000;
        unique case (state_q)
            ST_INIT: begin
                wr_en = 1'b1;
                idx_d = idx_q + ADDR_BITS'(1);
                if (idx_q == IDX_LAST) begin
                    state_d = ST_SERVE;
                end
            end
            ST_SERVE: begin
                // A write wins over a simultaneous read; out-of-range writes drop.
                if (!WE) begin
                    wr_en = in_range;
                    waddr = ADDR[ADDR_BITS-1:0];
                    wdata = Data_to_SRAM;
                end else if (!OE) begin
                    rd_issue = 1'b1;
                end
            end
            default: state_d = ST_INIT;
        endcase
    end

    // Read data is captured at the sampling edge, so a preceding write is seen.
    always_comb begin
        pv_d    = '0;
        pd_d    = pd_q;
        pv_d[0] = rd_issue;
        pd_d[0] = rd_data;
        for (int i = 1; i < RD_LATENCY; i++) begin
            pv_d[i] = pv_q[i-1];
            pd_d[i] = pd_q[i-1];
        end
        dout_d = pv_q[RD_LATENCY-1] ? pd_q[RD_LATENCY-1] : dout_q;
    end

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= ST_INIT;
            idx_q   <= '0;
            pv_q    <= '0;
            dout_q  <= 16'h0000;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            pv_q    <= pv_d;
            dout_q  <= dout_d;
        end
    end

    always_ff @(posedge Clk) begin
        pd_q <= pd_d;
    end

    always_ff @(posedge Clk) begin
        if (wr_en && !Reset) begin
            mem_q[waddr] <= wdata;
        end
    end

    assign Data_from_SRAM = dout_q;
    assign Ready          = (state_q == ST_SERVE);

endmodule

// File: tb/tb_sram_responder.sv
// Directed bench for sram_responder with a cycle-stamped read scoreboard.
module tb_sram_responder;

    localparam int AB = 10;
    localparam int L  = 1;
`ifdef SRAM_RESPONDER_PRELOAD_EN
    localparam logic [15:0] IMG0 = 16'h5020;
    localparam logic [15:0] IMG1 = 16'h1025;
`else
    localparam logic [15:0] IMG0 = 16'h0000;
    localparam logic [15:0] IMG1 = 16'h0000;
`endif

    logic        Clk;
    logic        Reset;
    logic [15:0] ADDR;
    logic [15:0] Data_to_SRAM;
    logic        OE;
    logic        WE;
    logic [15:0] Data_from_SRAM;
    logic        Ready;

    typedef struct {
        int          due;
        logic [15:0] val;
    } sb_t;

    sb_t         exp_q [$];
    logic [15:0] exp_dout;
    int          cyc;
    int          n_assert;
    int          n_fail;
    int          n;

    sram_responder #(
        .ADDR_BITS (AB),
        .RD_LATENCY(L)
    ) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .ADDR          (ADDR),
        .Data_to_SRAM  (Data_to_SRAM),
        .OE            (OE),
        .WE            (WE),
        .Data_from_SRAM(Data_from_SRAM),
        .Ready         (Ready)
    );

    initial Clk = 1'b0;
    always #5 Clk = ~Clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock; compares the output against the scoreboard every cycle.
    task automatic tick();
        logic r;
        r = Reset;
        @(posedge Clk);
        #1;
        cyc++;
        if (r) begin
            exp_q.delete();
            exp_dout = 16'h0000;
        end else if (exp_q.size() > 0 && exp_q[0].due == cyc) begin
            exp_dout = exp_q[0].val;
            void'(exp_q.pop_front());
        end
        check("dout", Data_from_SRAM, exp_dout);
    endtask

    task automatic idle(input int k);
        for (int i = 0; i < k; i++) tick();
    endtask

    task automatic wr(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        Data_to_SRAM = d;
        WE = 1'b0;
        OE = 1'b1;
        tick();
        WE = 1'b1;
    endtask

    task automatic rd(input logic [15:0] a, input logic [15:0] e);
        ADDR = a;
        OE = 1'b0;
        WE = 1'b1;
        exp_q.push_back('{due: cyc + 1 + L, val: e});
        tick();
        OE = 1'b1;
    endtask

    task automatic both(input logic [15:0] a, input logic [15:0] d);
        ADDR = a;
        Data_to_SRAM = d;
        OE = 1'b0;
        WE = 1'b0;
        tick();
        OE = 1'b1;
        WE = 1'b1;
    endtask

    task automatic wait_ready(output int k);
        k = 0;
        while (Ready !== 1'b1 && k < 1200) begin
            tick();
            k++;
        end
    endtask

    initial begin
        cyc = 0;
        n_assert = 0;
        n_fail = 0;
        exp_dout = 16'h0000;
        Reset = 1'b1;
        OE = 1'b1;
        WE = 1'b1;
        ADDR = 16'h0000;
        Data_to_SRAM = 16'h0000;
        tick();
        check("rst_ready", Ready, 0);

        Reset = 1'b0;
        ADDR = 16'h0030;
        Data_to_SRAM = 16'hDEAD;
        OE = 1'b0;
        WE = 1'b0;
        wait_ready(n);
        check("init_len", n, 1024);
        OE = 1'b1;
        WE = 1'b1;
        check("ready_up", Ready, 1);

        wr(16'h0010, 16'hBEEF);
        rd(16'h0010, 16'hBEEF);
        idle(L + 1);

        both(16'h0020, 16'h1234);
        idle(L + 1);
        rd(16'h0020, 16'h1234);

        wr(16'h0400, 16'hAAAA);
        rd(16'h0400, 16'h0000);
        rd(16'h0000, IMG0);
        rd(16'h8010, 16'h0000);
        rd(16'h0030, 16'h0000);
        rd(16'h0001, IMG1);
        idle(L + 1);

        ADDR = 16'h0040;
        WE = 1'b0;
        Data_to_SRAM = 16'h0001;
        tick();
        Data_to_SRAM = 16'h0002;
        tick();
        Data_to_SRAM = 16'h0003;
        tick();
        WE = 1'b1;
        rd(16'h0040, 16'h0003);
        rd(16'h0010, 16'hBEEF);
        rd(16'h0020, 16'h1234);
        idle(L + 2);

        wr(16'h0050, 16'h7777);
        rd(16'h0010, 16'hBEEF);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        check("midread_ready", Ready, 0);
        idle(500);
        check("midinit_ready", Ready, 0);
        Reset = 1'b1;
        tick();
        Reset = 1'b0;
        wait_ready(n);
        check("reinit_len", n, 1024);

        rd(16'h0050, 16'h0000);
        rd(16'h0010, 16'h0000);
        rd(16'h0000, IMG0);
        idle(L + 2);
        check("sb_empty", exp_q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule
